// File: rtl/lif_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lif_pkg : FSM state encoding and default neuron constants for lif_scheduler
// Revision 1.0
// ---------------------------------------------------------------------------
package lif_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    INT  = 3'd2,
    CHK  = 3'd3,
    WB   = 3'd4
  } state_t;

  localparam int LIF_WIDTH  = 8;
  localparam int LIF_THRESH = 20;
  localparam int LIF_ADD    = 8;
  localparam int LIF_LEAK   = 1;
  localparam int LIF_VRESET = 0;
  localparam int LIF_REFRAC = 3;

endpackage
`default_nettype wire

// File: rtl/lif_update.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lif_update : shared add/leak datapath with saturation and threshold compare
// Revision 1.0
// ---------------------------------------------------------------------------
module lif_update
  import lif_pkg::*;
#(
  parameter int               WIDTH  = LIF_WIDTH,
  parameter logic [WIDTH-1:0] ADD    = WIDTH'(LIF_ADD),
  parameter logic [WIDTH-1:0] LEAK   = WIDTH'(LIF_LEAK),
  parameter logic [WIDTH-1:0] THRESH = WIDTH'(LIF_THRESH)
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             hit,
  output logic [WIDTH-1:0] integ,
  output logic             over
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, acc} + {1'b0, ADD};

  // An event visit adds (clamped at all-ones); a quiet visit leaks (clamped at zero).
  always_comb begin
    integ = '0;
    if (hit) begin
      integ = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end else if (acc >= LEAK) begin
      integ = acc - LEAK;
    end
  end

  assign over = (acc >= THRESH);

endmodule
`default_nettype wire

// File: rtl/lif_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lif_scheduler : time-multiplexed leaky integrate-and-fire neuron channels
// Optional refractory counters: define LIF_REFRACTORY_EN.   Revision 1.0
// ---------------------------------------------------------------------------
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int               N_CH   = 4,
  parameter int               WIDTH  = LIF_WIDTH,
  parameter logic [WIDTH-1:0] THRESH = WIDTH'(LIF_THRESH),
  parameter logic [WIDTH-1:0] ADD    = WIDTH'(LIF_ADD),
  parameter logic [WIDTH-1:0] LEAK   = WIDTH'(LIF_LEAK),
  parameter logic [WIDTH-1:0] VRESET = WIDTH'(LIF_VRESET),
  parameter int               REFRAC = LIF_REFRAC,
  localparam int              CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [N_CH-1:0] spike_in,
  output logic [N_CH-1:0] spike_out,
  output logic            busy,
  output logic [CW-1:0]   cur_ch
);

  state_t           state;
  logic [WIDTH-1:0] pot [N_CH];
  logic [N_CH-1:0]  pending;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] integ;
  logic             over;
  logic             in_refr;
  logic             hold;

  lif_update #(
    .WIDTH (WIDTH),
    .ADD   (ADD),
    .LEAK  (LEAK),
    .THRESH(THRESH)
  ) u_update (
    .acc  (acc),
    .hit  (pending[cur_ch]),
    .integ(integ),
    .over (over)
  );

`ifdef LIF_REFRACTORY_EN
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [RW-1:0] refr_cnt [N_CH];

  assign in_refr = (refr_cnt[cur_ch] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) refr_cnt[i] <= '0;
    end else if (state == INT && in_refr) begin
      refr_cnt[cur_ch] <= refr_cnt[cur_ch] - 1'b1;
    end else if (state == CHK && over && !hold) begin
      refr_cnt[cur_ch] <= RW'(REFRAC);
    end
  end
`else
  assign in_refr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_ch    <= '0;
      acc       <= '0;
      hold      <= 1'b0;
      busy      <= 1'b0;
      spike_out <= '0;
      pending   <= '0;
      for (int i = 0; i < N_CH; i++) pot[i] <= VRESET;
    end else begin
      pending   <= pending | spike_in;
      spike_out <= '0;
      case (state)
        IDLE: begin
          if (run) begin
            state <= RD;
            busy  <= 1'b1;
          end
        end
        RD: begin
          acc   <= pot[cur_ch];
          state <= INT;
        end
        INT: begin
          // A fresh event arriving on the consuming cycle must not be lost.
          pending[cur_ch] <= spike_in[cur_ch];
          hold            <= in_refr;
          if (!in_refr) acc <= integ;
          state <= CHK;
        end
        CHK: begin
          // spike_out is the registered fire flag, visible during WB.
          if (over && !hold) begin
            acc               <= VRESET;
            spike_out[cur_ch] <= 1'b1;
          end
          state <= WB;
        end
        WB: begin
          pot[cur_ch] <= acc;
          cur_ch      <= (cur_ch == CW'(N_CH - 1)) ? '0 : cur_ch + 1'b1;
          if (run) begin
            state <= RD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lif_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lif_scheduler : scoreboard bench for lif_scheduler (defaults + ADD=200)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_lif_scheduler;

  localparam int N = 4;

  typedef struct {
    int           id;
    int           t;
    logic [N-1:0] mask;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b0;
  logic         run2 = 1'b0;
  logic [N-1:0] spike_in = '0;
  logic [N-1:0] spike_in2 = '0;
  logic [N-1:0] spike_out, spike_out2;
  logic         busy, busy2;
  logic [1:0]   cur_ch, cur_ch2;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];

  lif_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .spike_in (spike_in),
    .spike_out(spike_out),
    .busy     (busy),
    .cur_ch   (cur_ch)
  );

  lif_scheduler #(.ADD(8'd200), .THRESH(8'd250)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .run      (run2),
    .spike_in (spike_in2),
    .spike_out(spike_out2),
    .busy     (busy2),
    .cur_ch   (cur_ch2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
  endtask

  task automatic take_spike(input int id, input logic [N-1:0] m);
    exp_t e;
    if (sb.size() == 0) begin
      check($sformatf("unexpected_spike_dut%0d", id), m, 0);
    end else begin
      e = sb.pop_front();
      check("spike_dut", id, e.id);
      check("spike_cycle", cyc, e.t);
      check("spike_mask", m, e.mask);
    end
  endtask

  always @(negedge clk) begin
    if (spike_out != '0)  take_spike(0, spike_out);
    if (spike_out2 != '0) take_spike(1, spike_out2);
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse(input int id, input int ch, input int t);
    wait_to(t);
    if (id == 0) spike_in[ch] = 1'b1; else spike_in2[ch] = 1'b1;
    @(negedge clk);
    if (id == 0) spike_in[ch] = 1'b0; else spike_in2[ch] = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; run = 1'b0; run2 = 1'b0; spike_in = '0; spike_in2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, t2;
    do_reset;
    check("rst_busy", busy, 0);
    check("rst_cur_ch", cur_ch, 0);
    check("rst_spike", spike_out, 0);
    for (int i = 0; i < N; i++) check("rst_pot", dut.pot[i], 0);

    // ch0 event each sweep: 8, 16, then 24 fires on the third visit
    t0 = cyc;
    run = 1'b1;
    sb.push_back('{0, t0 + 36, 4'b0001});
    pulse(0, 0, t0);
    wait_to(t0 + 2);  check("busy_run", busy, 1);
    wait_to(t0 + 5);  check("ch0_pot_s0", dut.pot[0], 8);
    check("cur_ch_adv", cur_ch, 1);
    pulse(0, 0, t0 + 16);
    wait_to(t0 + 21); check("ch0_pot_s1", dut.pot[0], 16);
    pulse(0, 0, t0 + 32);
    wait_to(t0 + 37); check("ch0_pot_fire", dut.pot[0], 0);

    // single ch2 event then leak down to zero without underflow
    pulse(0, 2, t0 + 40);
    for (int j = 0; j < 10; j++) begin
      wait_to(t0 + 45 + 16 * j);
      check("ch2_leak", dut.pot[2], (j <= 8) ? 8 - j : 0);
    end

    // ch3 event lands in its own INT cycle: set wins over clear
    wait_to(t0 + 206);
    check("ch3_cur", cur_ch, 3);
    spike_in[3] = 1'b1;
    @(negedge clk);
    spike_in[3] = 1'b0;
    check("ch3_pending_kept", dut.pending[3], 1);
    wait_to(t0 + 209); check("ch3_pot_leak", dut.pot[3], 0);
    wait_to(t0 + 225); check("ch3_pot_late", dut.pot[3], 8);

    // drop run during INT of ch1: the channel completes, then IDLE on ch2
    wait_to(t0 + 246);
    check("ch1_cur", cur_ch, 1);
    run = 1'b0;
    wait_to(t0 + 248); check("stop_busy_wb", busy, 1);
    wait_to(t0 + 249); check("stop_busy", busy, 0);
    check("stop_cur_ch", cur_ch, 2);
    wait_to(t0 + 260); check("idle_busy", busy, 0);
    check("idle_cur_ch", cur_ch, 2);

    // event captured while IDLE, then reset in the CHK of a firing visit
    t1 = cyc;
    pulse(0, 2, t1);
    check("idle_pending", dut.pending[2], 1);
    t1 = cyc;
    run = 1'b1;
    wait_to(t1 + 5);  check("ch2_pot_a", dut.pot[2], 8);
    pulse(0, 2, t1 + 16);
    wait_to(t1 + 21); check("ch2_pot_b", dut.pot[2], 16);
    pulse(0, 2, t1 + 32);
    wait_to(t1 + 35);
    rst = 1'b1;
    #1;
    check("arst_spike", spike_out, 0);
    check("arst_busy", busy, 0);
    check("arst_cur_ch", cur_ch, 0);
    for (int i = 0; i < N; i++) check("arst_pot", dut.pot[i], 0);
    run = 1'b0;
    repeat (4) @(negedge clk);
    check("arst_spike_late", spike_out, 0);
    rst = 1'b0;

    // large increment saturates at 255 and fires instead of wrapping to 144
    @(negedge clk);
    t2 = cyc;
    run2 = 1'b1;
    sb.push_back('{1, t2 + 24, 4'b0010});
    pulse(1, 1, t2);
    wait_to(t2 + 9);  check("sat_pot_s0", dut2.pot[1], 200);
    pulse(1, 1, t2 + 16);
    wait_to(t2 + 25); check("sat_pot_fire", dut2.pot[1], 0);
    wait_to(t2 + 40);
    run2 = 1'b0;

`ifdef LIF_REFRACTORY_EN
    begin
      int t3;
      int rexp[7] = '{8, 16, 0, 0, 0, 0, 8};
      do_reset;
      t3 = cyc;
      run = 1'b1;
      sb.push_back('{0, t3 + 36, 4'b0001});
      for (int s = 0; s < 7; s++) begin
        pulse(0, 0, t3 + 16 * s);
        wait_to(t3 + 5 + 16 * s);
        check("refr_pot", dut.pot[0], rexp[s]);
      end
      run = 1'b0;
    end
`endif

    repeat (30) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of neuron channels sharing one accumulator datapath.
REQ-002 SHALL have parameter WIDTH, default 8: membrane potential width, unsigned.
REQ-003 SHALL have parameters THRESH=20, ADD=8, LEAK=1, VRESET=0, each WIDTH bits: firing threshold, per-event increment, per-visit decay, post-spike value.
REQ-004 SHALL have parameter REFRAC, default 3: refractory length in sweeps, used only when LIF_REFRACTORY_EN is defined.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 run  input  1  high: sweep channels continuously; low: stop at the next channel boundary.
REQ-008 spike_in  input  N_CH  per-channel input event, level-sampled every cycle.
REQ-009 spike_out  output  N_CH  per-channel output spike, one-cycle pulse.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 cur_ch  output  clog2(N_CH)  channel currently being serviced.

Function
REQ-012 SHALL hold one WIDTH-bit potential register per channel and one pending-event bit per channel.
REQ-013 SHALL set pending[i] in any cycle spike_in[i] is high, including while IDLE; multiple events between visits coalesce into one.
REQ-014 SHALL use FSM states IDLE, RD, INT, CHK, WB; IDLE->RD when run=1; RD->INT->CHK->WB unconditionally; WB->RD if run=1, else WB->IDLE.
REQ-015 RD: load potential of cur_ch into the shared accumulator.
REQ-016 INT: if pending[cur_ch], acc = min(acc+ADD, 2^WIDTH-1) computed in WIDTH+1 bits; else acc = max(acc-LEAK, 0); no leak on an event visit.
REQ-017 INT SHALL clear pending[cur_ch]; if spike_in[cur_ch] is high in that same cycle, set wins and the bit stays 1.
REQ-018 CHK: if acc >= THRESH, acc = VRESET and a fire flag is registered; otherwise acc is unchanged.
REQ-019 spike_out[cur_ch] SHALL be high for exactly the WB cycle following a firing CHK; all other bits stay 0.
REQ-020 WB: write acc to the potential register of cur_ch, then cur_ch = (cur_ch+1) mod N_CH.
REQ-021 Service time SHALL be 4 cycles per channel; one sweep is 4*N_CH cycles; latency from spike_in to spike_out is at most 4*N_CH+3 cycles.
REQ-022 Deasserting run mid-channel SHALL NOT abort it; the channel completes through WB, then the FSM enters IDLE with cur_ch already advanced.

Reset
REQ-023 On rst: FSM=IDLE, cur_ch=0, all potentials=VRESET, all pending=0, acc=0, spike_out=0, busy=0.
REQ-024 Reset asserted mid-channel SHALL discard the in-flight update; no spike_out pulse is emitted for it.

Configuration
REQ-025 With LIF_REFRACTORY_EN defined: a firing channel loads a per-channel counter with REFRAC; on each visit with counter>0, INT decrements the counter, clears pending, and leaves acc unchanged (no add, no leak, no fire).
REQ-026 Without LIF_REFRACTORY_EN: no refractory counters exist, and behaviour is exactly REQ-016 to REQ-020.

Structure
REQ-027 Package lif_pkg SHALL hold the FSM state enum and the default constants (WIDTH, THRESH, ADD, LEAK, VRESET, REFRAC).
REQ-028 Sub-module lif_update SHALL be the single shared datapath: add/leak with saturation and the threshold compare, instantiated once.

Verification
REQ-029 Defaults; spike_in[0] pulsed once per sweep, run=1 -> ch0 potential 8, 16, then 24>=20 fires on sweep 3: spike_out[0] one-cycle pulse, potential written 0.
REQ-030 Single spike_in[2] pulse then none -> ch2 = 8, then 7, 6 ... 0 over 8 later sweeps, stays 0 (no underflow), no spike.
REQ-031 ADD=200; two events on ch1 across sweeps -> second INT saturates at 255, CHK fires; no wrap to 144.
REQ-032 spike_in[3] high in the exact INT cycle of ch3 -> pending[3] remains 1 and is consumed on the next sweep.
REQ-033 run dropped during INT of ch1 -> CHK, WB of ch1 complete, IDLE with cur_ch=2, busy=0; rst asserted during CHK of a firing channel -> no spike_out, all potentials 0.
REQ-034 LIF_REFRACTORY_EN, REFRAC=3; ch0 fires, then an event every sweep -> 3 sweeps with potential 0 and no fire, then integration resumes at 8.
